st7735_init_seq: RTL and testbench
==================================

# st7735_init_seq

Parametrised ST7735 power-up sequencer. It drives the panel hardware reset pin, then walks a 19-byte command/data program with the required post-command delays. Bytes are handed to the SPI byte transmitter over a valid/ready handshake. The program is the earlier fixed init table, generalised: the display window (size and panel offset), MADCTL, COLMOD and every delay are parameters. It sits between the top-level control logic (start/done) and the SPI shifter.

## Interface
Parameters:
- TICKS_PER_MS, 27000, clk cycles per millisecond of delay (set small in simulation)
- WIDTH, 128, visible columns (1..256)
- HEIGHT, 160, visible rows (1..256)
- COL_OFS, 0, first panel column of the window
- ROW_OFS, 0, first panel row of the window
- MADCTL, 8'h00, MADCTL data byte
- COLMOD, 8'h05, COLMOD data byte (16-bit colour)
- HWRST_LOW_MS, 1, hw_rst_n low time
- HWRST_WAIT_MS, 120, wait after hw_rst_n rises
- SWRESET_MS, 150, delay after SWRESET
- SLPOUT_MS, 120, delay after SLPOUT
- DISPON_MS, 10, delay after DISPON

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous, active-low reset
- start  in  1  single-cycle request to run the sequence
- busy  out  1  high while the sequence runs
- done  out  1  high after completion; held until the next accepted start or reset
- hw_rst_n  out  1  panel RESX pin
- tx_valid  out  1  byte offered to the SPI transmitter
- tx_ready  in  1  transmitter accepts the byte this cycle
- tx_is_data  out  1  D/C level: 0 = command, 1 = data
- tx_byte  out  8  byte to send

## Operation
- All outputs are registered. Reset values: busy=0, done=0, hw_rst_n=1, tx_valid=0, tx_is_data=0, tx_byte=8'h00.
- State machine:
  - IDLE: wait for start.
  - HWRST_LOW: hw_rst_n=0 for HWRST_LOW_MS.
  - HWRST_WAIT: hw_rst_n=1 for HWRST_WAIT_MS.
  - SEND: offer program[idx].
  - DELAY: wait the per-entry delay.
  - DONE: sequence complete.
- start is accepted only in IDLE or DONE. It is ignored while busy. Acceptance clears done, sets busy and enters HWRST_LOW.
- Program, given as idx: cmd/data byte:
  - 0: C 01 (SWRESET), then SWRESET_MS delay
  - 1: C 11 (SLPOUT), then SLPOUT_MS delay
  - 2: C 3A
  - 3: D COLMOD
  - 4: C 36
  - 5: D MADCTL
  - 6: C 2A
  - 7–10: D xs[15:8], xs[7:0], xe[15:8], xe[7:0]
  - 11: C 2B
  - 12–15: D ys[15:8], ys[7:0], ye[15:8], ye[7:0]
  - 16: C 13
  - 17: C 29, then DISPON_MS delay
  - 18: C 2C
- Window arithmetic, all 16-bit unsigned, big-endian on the wire:
  - xs = COL_OFS, xe = COL_OFS+WIDTH-1
  - ys = ROW_OFS, ye = ROW_OFS+HEIGHT-1
- Handshake:
  - A transfer occurs on any cycle with tx_valid&&tx_ready.
  - While tx_valid=1 and tx_ready=0, tx_byte and tx_is_data hold stable.
  - tx_ready while tx_valid=0 has no effect.
  - Back-to-back: if the accepted entry has no delay and is not idx 18, the next cycle presents idx+1 with tx_valid kept at 1.
- DELAY: tx_valid=0. Lasts exactly N*TICKS_PER_MS cycles for an N ms delay. A delay parameter of 0 skips DELAY entirely (back-to-back rule applies).
- The delay counter is wide enough for the largest delay times TICKS_PER_MS. It is shared by the HWRST states and DELAY.
- After idx 18 is accepted: tx_valid=0, busy=0, done=1, state DONE.
- rst_n=0 in any state, including mid-handshake or mid-delay, forces reset values and IDLE on the next edge. Any pending byte is abandoned.

## Timing
- start sampled at edge T → busy=1 and hw_rst_n=0 from T+1.
- hw_rst_n stays 0 for HWRST_LOW_MS*TICKS_PER_MS cycles, then 1 for HWRST_WAIT_MS*TICKS_PER_MS cycles.
- tx_valid rises with idx 0 on the following cycle.
- Byte accepted at edge A: the next byte appears at A+1 (no delay) or at A+1+N*TICKS_PER_MS (N ms delay).
- done=1 and busy=0 from the cycle after idx 18 is accepted.
- With tx_ready tied 1, total latency from start to done = 1 + TICKS_PER_MS*(HWRST_LOW_MS+HWRST_WAIT_MS+SWRESET_MS+SLPOUT_MS+DISPON_MS) + 19 cycles.

## Test plan
- Nominal run: TICKS_PER_MS=4, defaults, tx_ready=1, pulse start.
  - Capture exactly 19 transfers matching the program: 01,11,3A,05,36,00,2A,00,00,00,7F,2B,00,00,00,9F,13,29,2C.
  - D/C per entry as listed.
  - done rises 1+4*401+19 cycles after start.
- Offsets: WIDTH=128, HEIGHT=128, COL_OFS=2, ROW_OFS=1.
  - CASET data = 00,02,00,81.
  - RASET data = 00,01,00,80.
- Backpressure: tx_ready random 30% duty.
  - Same byte sequence.
  - tx_byte and tx_is_data never change while tx_valid=1 and tx_ready=0.
  - No byte is duplicated or dropped.
- Delays: check these gaps in cycles (TICKS_PER_MS=4):
  - idx0→idx1 gap 600.
  - idx1→idx2 gap 480.
  - idx17→idx18 gap 40.
  - With DISPON_MS=0, idx17→idx18 is back-to-back.
- Start filtering: start pulses during HWRST_LOW, during SEND and during DELAY are ignored. start in DONE clears done and replays the full sequence, including the hw_rst_n low pulse.
- Mid-run reset: assert rst_n=0 for 1 cycle while tx_valid=1 at idx 8, and again mid-DELAY.
  - All outputs return to reset values on the next edge.
  - A later start runs the full sequence from idx 0.

Source files
------------

// File: rtl/st7735_init_seq.sv
// ST7735 power-up sequencer: pulses the panel reset pin, then streams the
// 19-entry command/data init program to the SPI byte transmitter with the post-command delays.
module st7735_init_seq #(
  parameter int unsigned TICKS_PER_MS  = 27000,
  parameter int unsigned WIDTH         = 128,
  parameter int unsigned HEIGHT        = 160,
  parameter int unsigned COL_OFS       = 0,
  parameter int unsigned ROW_OFS       = 0,
  parameter logic [7:0]  MADCTL        = 8'h00,
  parameter logic [7:0]  COLMOD        = 8'h05,
  parameter int unsigned HWRST_LOW_MS  = 1,
  parameter int unsigned HWRST_WAIT_MS = 120,
  parameter int unsigned SWRESET_MS    = 150,
  parameter int unsigned SLPOUT_MS     = 120,
  parameter int unsigned DISPON_MS     = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       hw_rst_n,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       tx_is_data,
  output logic [7:0] tx_byte
);

  localparam int unsigned LOW_T  = HWRST_LOW_MS  * TICKS_PER_MS;
  localparam int unsigned WAIT_T = HWRST_WAIT_MS * TICKS_PER_MS;
  localparam int unsigned SWR_T  = SWRESET_MS    * TICKS_PER_MS;
  localparam int unsigned SLP_T  = SLPOUT_MS     * TICKS_PER_MS;
  localparam int unsigned DON_T  = DISPON_MS     * TICKS_PER_MS;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    max2 = (a > b) ? a : b;
  endfunction

  localparam int unsigned MAX_T = max2(max2(LOW_T, WAIT_T), max2(max2(SWR_T, SLP_T), DON_T));
  localparam int unsigned CW    = (MAX_T < 1) ? 1 : $clog2(MAX_T + 1);

  localparam logic [15:0] XS = 16'(COL_OFS);
  localparam logic [15:0] XE = 16'(COL_OFS + WIDTH - 1);
  localparam logic [15:0] YS = 16'(ROW_OFS);
  localparam logic [15:0] YE = 16'(ROW_OFS + HEIGHT - 1);
  localparam logic [4:0]  LAST_IDX = 5'd18;

  typedef enum logic [2:0] {IDLE, HWRST_LOW, HWRST_WAIT, SEND, DELAY, DONE} state_t;

  state_t         state;
  logic [4:0]     idx;
  logic [4:0]     idx_nxt;
  logic [CW-1:0]  cnt;

  // {is_data, byte} for each program entry
  function automatic logic [8:0] prog(input logic [4:0] i);
    case (i)
      5'd0:    prog = {1'b0, 8'h01};
      5'd1:    prog = {1'b0, 8'h11};
      5'd2:    prog = {1'b0, 8'h3A};
      5'd3:    prog = {1'b1, COLMOD};
      5'd4:    prog = {1'b0, 8'h36};
      5'd5:    prog = {1'b1, MADCTL};
      5'd6:    prog = {1'b0, 8'h2A};
      5'd7:    prog = {1'b1, XS[15:8]};
      5'd8:    prog = {1'b1, XS[7:0]};
      5'd9:    prog = {1'b1, XE[15:8]};
      5'd10:   prog = {1'b1, XE[7:0]};
      5'd11:   prog = {1'b0, 8'h2B};
      5'd12:   prog = {1'b1, YS[15:8]};
      5'd13:   prog = {1'b1, YS[7:0]};
      5'd14:   prog = {1'b1, YE[15:8]};
      5'd15:   prog = {1'b1, YE[7:0]};
      5'd16:   prog = {1'b0, 8'h13};
      5'd17:   prog = {1'b0, 8'h29};
      default: prog = {1'b0, 8'h2C};
    endcase
  endfunction

  function automatic int unsigned post_ticks(input logic [4:0] i);
    case (i)
      5'd0:    post_ticks = SWR_T;
      5'd1:    post_ticks = SLP_T;
      5'd17:   post_ticks = DON_T;
      default: post_ticks = 0;
    endcase
  endfunction

  assign idx_nxt = idx + 5'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      cnt        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      hw_rst_n   <= 1'b1;
      tx_valid   <= 1'b0;
      tx_is_data <= 1'b0;
      tx_byte    <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            done <= 1'b0;
            busy <= 1'b1;
            idx  <= '0;
            if (LOW_T != 0) begin
              state    <= HWRST_LOW;
              hw_rst_n <= 1'b0;
              cnt      <= CW'(LOW_T - 1);
            end else if (WAIT_T != 0) begin
              state <= HWRST_WAIT;
              cnt   <= CW'(WAIT_T - 1);
            end else begin
              state                 <= SEND;
              tx_valid              <= 1'b1;
              {tx_is_data, tx_byte} <= prog(5'd0);
            end
          end
        end
        HWRST_LOW: begin
          if (cnt == '0) begin
            hw_rst_n <= 1'b1;
            if (WAIT_T != 0) begin
              state <= HWRST_WAIT;
              cnt   <= CW'(WAIT_T - 1);
            end else begin
              state                 <= SEND;
              tx_valid              <= 1'b1;
              {tx_is_data, tx_byte} <= prog(5'd0);
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        HWRST_WAIT: begin
          if (cnt == '0) begin
            state                 <= SEND;
            tx_valid              <= 1'b1;
            {tx_is_data, tx_byte} <= prog(5'd0);
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        SEND: begin
          if (tx_ready) begin
            if (idx == LAST_IDX) begin
              state    <= DONE;
              tx_valid <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
            end else if (post_ticks(idx) != 0) begin
              state    <= DELAY;
              tx_valid <= 1'b0;
              cnt      <= CW'(post_ticks(idx) - 1);
            end else begin
              idx                   <= idx_nxt;
              {tx_is_data, tx_byte} <= prog(idx_nxt);
            end
          end
        end
        DELAY: begin
          // idx still names the entry just sent; advance when the wait expires
          if (cnt == '0) begin
            state                 <= SEND;
            tx_valid              <= 1'b1;
            idx                   <= idx_nxt;
            {tx_is_data, tx_byte} <= prog(idx_nxt);
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_st7735_init_seq.sv
// Scoreboard bench for st7735_init_seq: three instances (defaults, window offsets,
// zero DISPON delay) with TICKS_PER_MS=4; transfers are queued by a monitor and popped against expectations.
module tb_st7735_init_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [2:0] start, busy, done, hwrst, valid, rdy, dc;
  logic [7:0] byt [3];
  logic [2:0] hold_rdy, rnd, rand_mode;

  assign rdy = (rand_mode & rnd) | (~rand_mode & hold_rdy);

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rnd <= {($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 3)};

  int tests_run = 0;
  int failed    = 0;

  typedef struct {
    int unsigned cyc;
    logic [8:0]  w;
  } xfer_t;

  xfer_t       obs_q [3][$];
  logic [8:0]  exp_q [3][$];
  int unsigned low_cnt [3];
  int unsigned stab_err [3];
  logic        stall [3];
  logic [8:0]  stall_w [3];

  initial begin
    for (int k = 0; k < 3; k++) begin
      low_cnt[k] = 0; stab_err[k] = 0; stall[k] = 1'b0; stall_w[k] = '0;
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      xfer_t x;
      if (stall[k] && (!valid[k] || {dc[k], byt[k]} !== stall_w[k])) stab_err[k]++;
      stall[k]   = valid[k] && !rdy[k];
      stall_w[k] = {dc[k], byt[k]};
      if (valid[k] && rdy[k]) begin
        x.cyc = cyc;
        x.w   = {dc[k], byt[k]};
        obs_q[k].push_back(x);
      end
      if (!hwrst[k]) low_cnt[k]++;
    end
  end

  st7735_init_seq #(.TICKS_PER_MS(4)) u_nom (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .busy(busy[0]), .done(done[0]),
    .hw_rst_n(hwrst[0]), .tx_valid(valid[0]), .tx_ready(rdy[0]), .tx_is_data(dc[0]), .tx_byte(byt[0]));

  st7735_init_seq #(.TICKS_PER_MS(4), .WIDTH(128), .HEIGHT(128), .COL_OFS(2), .ROW_OFS(1)) u_ofs (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .busy(busy[1]), .done(done[1]),
    .hw_rst_n(hwrst[1]), .tx_valid(valid[1]), .tx_ready(rdy[1]), .tx_is_data(dc[1]), .tx_byte(byt[1]));

  st7735_init_seq #(.TICKS_PER_MS(4), .DISPON_MS(0)) u_nodly (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .busy(busy[2]), .done(done[2]),
    .hw_rst_n(hwrst[2]), .tx_valid(valid[2]), .tx_ready(rdy[2]), .tx_is_data(dc[2]), .tx_byte(byt[2]));

  function automatic logic [8:0] exp_word(input int cfg, input int i);
    logic [7:0] b;
    logic       d;
    case (i)
      0: b = 8'h01;  1: b = 8'h11;  2: b = 8'h3A;  3: b = 8'h05;
      4: b = 8'h36;  5: b = 8'h00;  6: b = 8'h2A;  7: b = 8'h00;
      8: b = 8'h00;  9: b = 8'h00; 10: b = 8'h7F; 11: b = 8'h2B;
      12: b = 8'h00; 13: b = 8'h00; 14: b = 8'h00; 15: b = 8'h9F;
      16: b = 8'h13; 17: b = 8'h29; default: b = 8'h2C;
    endcase
    if (cfg == 1) begin
      case (i)
        8: b = 8'h02; 10: b = 8'h81; 13: b = 8'h01; 15: b = 8'h80;
        default: ;
      endcase
    end
    d = (i == 3) || (i == 5) || (i >= 7 && i <= 10) || (i >= 12 && i <= 15);
    return {d, b};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_expected(input int k, input int cfg);
    for (int i = 0; i < 19; i++) exp_q[k].push_back(exp_word(cfg, i));
  endtask

  task automatic flush_obs(input int k);
    while (obs_q[k].size() != 0) void'(obs_q[k].pop_front());
  endtask

  task automatic do_start(input int k, output int unsigned st);
    step();
    start[k] = 1'b1;
    st = cyc;
    step();
    start[k] = 1'b0;
  endtask

  task automatic wait_done(input int k, input int unsigned st, input bit chk_lat,
                           input int unsigned exp_lat, input string name);
    int unsigned n = 0;
    @(negedge clk);
    while (!done[k] && n < 8000) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (!done[k]) begin
      failed++;
      $display("FAIL %s done: timed out, done=%b required 1", name, done[k]);
    end else if (chk_lat && (cyc - st) !== exp_lat) begin
      failed++;
      $display("FAIL %s latency: got %0d cycles, required %0d", name, cyc - st, exp_lat);
    end
  endtask

  task automatic check_seq(input int k, input string name, input bit do_gaps,
                           input int unsigned g0, input int unsigned g1, input int unsigned g17);
    xfer_t       o;
    logic [8:0]  e;
    int unsigned prev = 0;
    int unsigned eg;
    for (int i = 0; i < 19; i++) begin
      tests_run++;
      if (obs_q[k].size() == 0 || exp_q[k].size() == 0) begin
        failed++;
        $display("FAIL %s idx%0d: transfer missing (observed %0d queued, expected %0d queued)",
                 name, i, obs_q[k].size(), exp_q[k].size());
      end else begin
        o = obs_q[k].pop_front();
        e = exp_q[k].pop_front();
        if (o.w !== e) begin
          failed++;
          $display("FAIL %s idx%0d: got dc=%b byte=%02h, required dc=%b byte=%02h",
                   name, i, o.w[8], o.w[7:0], e[8], e[7:0]);
        end
        if (do_gaps && i > 0) begin
          eg = (i == 1) ? g0 : (i == 2) ? g1 : (i == 18) ? g17 : 0;
          tests_run++;
          if (o.cyc - prev - 1 !== eg) begin
            failed++;
            $display("FAIL %s gap idx%0d->idx%0d: got %0d cycles, required %0d",
                     name, i - 1, i, o.cyc - prev - 1, eg);
          end
        end
        prev = o.cyc;
      end
    end
    tests_run++;
    if (obs_q[k].size() != 0) begin
      failed++;
      $display("FAIL %s extra transfers: got %0d surplus, required 0", name, obs_q[k].size());
    end
    flush_obs(k);
    exp_q[k].delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      tests_run++;
      if ({busy[k], done[k], hwrst[k], valid[k], dc[k], byt[k]} !== 13'b0_0_1_0_0_00000000) begin
        failed++;
        $display("FAIL reset inst%0d: got busy=%b done=%b hw_rst_n=%b valid=%b dc=%b byte=%02h, required 0 0 1 0 0 00",
                 k, busy[k], done[k], hwrst[k], valid[k], dc[k], byt[k]);
      end
    end
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_nominal();
    int unsigned st, l0;
    l0 = low_cnt[0];
    push_expected(0, 0);
    do_start(0, st);
    @(negedge clk);
    tests_run++;
    if ({busy[0], hwrst[0]} !== 2'b10) begin
      failed++;
      $display("FAIL nominal after start: got busy=%b hw_rst_n=%b, required 1 0", busy[0], hwrst[0]);
    end
    wait_done(0, st, 1'b1, 1624, "nominal");
    tests_run++;
    if (low_cnt[0] - l0 !== 4) begin
      failed++;
      $display("FAIL nominal hw_rst_n low: got %0d cycles, required 4", low_cnt[0] - l0);
    end
    tests_run++;
    if (busy[0] !== 1'b0) begin
      failed++;
      $display("FAIL nominal busy at done: got %b, required 0", busy[0]);
    end
    check_seq(0, "nominal", 1'b1, 600, 480, 40);
  endtask

  task automatic test_offsets();
    int unsigned st;
    push_expected(1, 1);
    do_start(1, st);
    wait_done(1, st, 1'b1, 1624, "offsets");
    check_seq(1, "offsets", 1'b1, 600, 480, 40);
  endtask

  task automatic test_dispon_zero();
    int unsigned st;
    push_expected(2, 0);
    do_start(2, st);
    wait_done(2, st, 1'b1, 1584, "dispon0");
    check_seq(2, "dispon0", 1'b1, 600, 480, 0);
  endtask

  task automatic test_backpressure();
    int unsigned st, s0;
    s0 = stab_err[0];
    rand_mode[0] = 1'b1;
    push_expected(0, 0);
    do_start(0, st);
    wait_done(0, st, 1'b0, 0, "backpressure");
    rand_mode[0] = 1'b0;
    tests_run++;
    if (stab_err[0] - s0 !== 0) begin
      failed++;
      $display("FAIL backpressure stability: got %0d changes while stalled, required 0", stab_err[0] - s0);
    end
    check_seq(0, "backpressure", 1'b0, 0, 0, 0);
  endtask

  task automatic test_start_filter();
    int unsigned st, l0, n;
    push_expected(0, 0);
    do_start(0, st);
    step();
    start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    n = 0;
    @(negedge clk);
    while (!valid[0] && n < 3000) begin
      @(negedge clk);
      n++;
    end
    start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    repeat (50) step();
    start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    wait_done(0, st, 1'b1, 1624, "start_filter");
    check_seq(0, "start_filter", 1'b1, 600, 480, 40);
    l0 = low_cnt[0];
    push_expected(0, 0);
    do_start(0, st);
    @(negedge clk);
    tests_run++;
    if ({done[0], busy[0], hwrst[0]} !== 3'b010) begin
      failed++;
      $display("FAIL replay accept: got done=%b busy=%b hw_rst_n=%b, required 0 1 0", done[0], busy[0], hwrst[0]);
    end
    wait_done(0, st, 1'b1, 1624, "replay");
    tests_run++;
    if (low_cnt[0] - l0 !== 4) begin
      failed++;
      $display("FAIL replay hw_rst_n low: got %0d cycles, required 4", low_cnt[0] - l0);
    end
    check_seq(0, "replay", 1'b1, 600, 480, 40);
  endtask

  task automatic test_mid_reset();
    int unsigned st, n;
    flush_obs(0);
    do_start(0, st);
    n = 0;
    while (obs_q[0].size() < 8 && n < 3000) begin
      step();
      n++;
    end
    hold_rdy[0] = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({valid[0], dc[0]} !== 2'b11) begin
      failed++;
      $display("FAIL midreset idx8 offered: got valid=%b dc=%b, required 1 1", valid[0], dc[0]);
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    hold_rdy[0] = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({busy[0], done[0], hwrst[0], valid[0], dc[0], byt[0]} !== 13'b0_0_1_0_0_00000000) begin
      failed++;
      $display("FAIL midreset handshake: got busy=%b done=%b hw_rst_n=%b valid=%b dc=%b byte=%02h, required 0 0 1 0 0 00",
               busy[0], done[0], hwrst[0], valid[0], dc[0], byt[0]);
    end
    flush_obs(0);
    do_start(0, st);
    n = 0;
    while (obs_q[0].size() < 1 && n < 3000) begin
      step();
      n++;
    end
    repeat (100) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({busy[0], done[0], hwrst[0], valid[0], dc[0], byt[0]} !== 13'b0_0_1_0_0_00000000) begin
      failed++;
      $display("FAIL midreset delay: got busy=%b done=%b hw_rst_n=%b valid=%b dc=%b byte=%02h, required 0 0 1 0 0 00",
               busy[0], done[0], hwrst[0], valid[0], dc[0], byt[0]);
    end
    flush_obs(0);
    push_expected(0, 0);
    do_start(0, st);
    wait_done(0, st, 1'b1, 1624, "after_reset");
    check_seq(0, "after_reset", 1'b1, 600, 480, 40);
  endtask

  initial begin
    start     = '0;
    hold_rdy  = '1;
    rand_mode = '0;
    test_reset();
    test_nominal();
    test_offsets();
    test_dispon_zero();
    test_backpressure();
    test_start_filter();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
